// File: rtl/us_pkg.sv
// rtl/us_pkg.sv - shared state type, zone codes and echo-width classifier for the ranging scheduler
package us_pkg;

  typedef enum logic [1:0] {
    GAP       = 2'd0,
    TRIG      = 2'd1,
    WAIT_ECHO = 2'd2,
    MEASURE   = 2'd3
  } us_state_t;

  localparam logic [1:0] ZONE_NEAR = 2'b01;
  localparam logic [1:0] ZONE_MID  = 2'b10;
  localparam logic [1:0] ZONE_FAR  = 2'b00;

  localparam int US_CNT_W = 16;

  // Map an echo width in microseconds onto a zone code; thresholds are exclusive upper bounds
  function automatic logic [1:0] classify(input logic [US_CNT_W-1:0] meas_us,
                                          input logic [US_CNT_W-1:0] thr1,
                                          input logic [US_CNT_W-1:0] thr2);
    logic [1:0] zone;
    if (meas_us < thr1) begin
      zone = ZONE_NEAR;
    end else if (meas_us < thr2) begin
      zone = ZONE_MID;
    end else begin
      zone = ZONE_FAR;
    end
    return zone;
  endfunction

endpackage

// File: rtl/us_tick.sv
// rtl/us_tick.sv - restartable microsecond prescaler, one-clock tick every US_DIV clocks
module us_tick #(
  parameter int US_DIV = 50
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(US_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // The tick marks the last clock of each microsecond, so a cleared divider ticks US_DIV clocks later
  assign tick = (div_cnt == DIV_LAST);

  // Divider wraps on every tick and is forced to zero when the scheduler changes state
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/us_ranging_scheduler.sv
// rtl/us_ranging_scheduler.sv - round-robin HC-SR04 trigger/echo scheduler with zone classification; optional US_ZONE_FILTER_EN
module us_ranging_scheduler
  import us_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int US_DIV          = 50,
  parameter int TRIG_US         = 10,
  parameter int GAP_US          = 31_250,
  parameter int ECHO_TIMEOUT_US = 30_000,
  parameter int MAX_ECHO_US     = 25_000,
  parameter int THRESHOLD1      = 1160,
  parameter int THRESHOLD2      = 2320
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        echo1,
  input  logic        echo2,
  output logic        trig1,
  output logic        trig2,
  output logic [1:0]  zone1,
  output logic [1:0]  zone2,
  output logic        meas_valid,
  output logic        meas_sel,
  output logic [15:0] meas_us,
  output logic        timeout
);

  // A zero US_DIV falls back to deriving the prescale from the clock frequency
  localparam int US_DIV_EFF = (US_DIV > 0) ? US_DIV : (CLK_FREQ / 1_000_000);

  localparam logic [US_CNT_W-1:0] GAP_LAST  = US_CNT_W'(GAP_US - 1);
  localparam logic [US_CNT_W-1:0] TRIG_LAST = US_CNT_W'(TRIG_US - 1);
  localparam logic [US_CNT_W-1:0] TMO_LAST  = US_CNT_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [US_CNT_W-1:0] MAX_LAST  = US_CNT_W'(MAX_ECHO_US - 1);
  localparam logic [US_CNT_W-1:0] MAX_US    = US_CNT_W'(MAX_ECHO_US);
  localparam logic [US_CNT_W-1:0] THR1      = US_CNT_W'(THRESHOLD1);
  localparam logic [US_CNT_W-1:0] THR2      = US_CNT_W'(THRESHOLD2);

  us_state_t           state;
  logic                sel;
  logic [US_CNT_W-1:0] us_cnt;
  logic [1:0]          echo1_sync;
  logic [1:0]          echo2_sync;
  logic                echo_prev;
  logic                echo_sel;
  logic                echo_rise;
  logic                tick;
  logic                leave;
  logic                fin;
  logic                fin_to;
  logic [US_CNT_W-1:0] fin_us;
  logic [1:0]          fin_code;

  us_tick #(
    .US_DIV (US_DIV_EFF)
  ) u_tick (
    .clk50 (clk50),
    .rst_n (rst_n),
    .clear (leave),
    .tick  (tick)
  );

  // Two-flop synchronizers; nothing downstream ever sees the raw echo pins
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      echo1_sync <= 2'b00;
      echo2_sync <= 2'b00;
    end else begin
      echo1_sync <= {echo1_sync[0], echo1};
      echo2_sync <= {echo2_sync[0], echo2};
    end
  end

  assign echo_sel  = sel ? echo2_sync[1] : echo1_sync[1];
  assign echo_rise = echo_sel & ~echo_prev;

  // Previous level of the selected echo; an echo already high on WAIT_ECHO entry gives no rising edge
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      echo_prev <= 1'b0;
    end else begin
      echo_prev <= echo_sel;
    end
  end

  // State-exit and slot-finish conditions; leaving a state also restarts the prescaler
  always_comb begin
    leave  = 1'b0;
    fin    = 1'b0;
    fin_to = 1'b0;
    fin_us = '0;
    unique case (state)
      GAP: begin
        leave = tick && (us_cnt == GAP_LAST);
      end
      TRIG: begin
        leave = tick && (us_cnt == TRIG_LAST);
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          leave = 1'b1;
        end else if (tick && (us_cnt == TMO_LAST)) begin
          leave  = 1'b1;
          fin    = 1'b1;
          fin_to = 1'b1;
        end
      end
      MEASURE: begin
        // The saturation check wins over a coincident falling edge
        if (tick && (us_cnt == MAX_LAST)) begin
          leave  = 1'b1;
          fin    = 1'b1;
          fin_to = 1'b1;
          fin_us = MAX_US;
        end else if (!echo_sel) begin
          leave  = 1'b1;
          fin    = 1'b1;
          fin_us = us_cnt + {{(US_CNT_W-1){1'b0}}, tick};
        end
      end
      default: begin
        leave = 1'b0;
      end
    endcase
  end

  assign fin_code = fin_to ? ZONE_FAR : classify(fin_us, THR1, THR2);

  // Slot sequencer with registered trigger and measurement outputs
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GAP;
      sel        <= 1'b0;
      us_cnt     <= '0;
      trig1      <= 1'b0;
      trig2      <= 1'b0;
      meas_valid <= 1'b0;
      meas_sel   <= 1'b0;
      meas_us    <= '0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (leave) begin
        us_cnt <= '0;
      end else if (tick) begin
        us_cnt <= us_cnt + 1'b1;
      end
      unique case (state)
        GAP: begin
          if (leave) begin
            state <= TRIG;
            trig1 <= ~sel;
            trig2 <= sel;
          end
        end
        TRIG: begin
          if (leave) begin
            state <= WAIT_ECHO;
            trig1 <= 1'b0;
            trig2 <= 1'b0;
          end
        end
        WAIT_ECHO: begin
          if (echo_rise) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          state <= MEASURE;
        end
        default: begin
          state <= GAP;
        end
      endcase
      if (fin) begin
        state      <= GAP;
        sel        <= ~sel;
        meas_valid <= 1'b1;
        meas_sel   <= sel;
        meas_us    <= fin_us;
        timeout    <= fin_to;
      end
    end
  end

`ifdef US_ZONE_FILTER_EN
  logic [1:0] pend1;
  logic [1:0] pend2;

  // A zone only moves once two consecutive slots of that sensor agree on the new code
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      zone1 <= ZONE_FAR;
      zone2 <= ZONE_FAR;
      pend1 <= ZONE_FAR;
      pend2 <= ZONE_FAR;
    end else if (fin) begin
      if (!sel) begin
        if (fin_code == pend1) begin
          zone1 <= fin_code;
        end
        pend1 <= fin_code;
      end else begin
        if (fin_code == pend2) begin
          zone2 <= fin_code;
        end
        pend2 <= fin_code;
      end
    end
  end
`else
  // Zone of the serviced sensor follows every finished slot; the other sensor's zone holds
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      zone1 <= ZONE_FAR;
      zone2 <= ZONE_FAR;
    end else if (fin) begin
      if (!sel) begin
        zone1 <= fin_code;
      end else begin
        zone2 <= fin_code;
      end
    end
  end
`endif

endmodule
